// File: rtl/pc_sequencer.sv
// Program counter / next-address stage with I/O handshake stalls and sticky halt.
// Optional macro HALT_RESUME_EN adds a resume input that leaves HALTED.
module pc_sequencer #(
    parameter int unsigned        ADDR_W   = 10,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pcctrl,
    input  logic [1:0]        jump,
    input  logic              branch,
    input  logic              branchtype,
    input  logic              alu_zero,
    input  logic              inctrl,
    input  logic              outctrl,
    input  logic [ADDR_W-1:0] jtarget,
    input  logic [ADDR_W-1:0] boffset,
    input  logic [ADDR_W-1:0] jreg,
    input  logic              in_valid,
    input  logic              out_ready,
`ifdef HALT_RESUME_EN
    input  logic              resume,
`endif
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus1,
    output logic              commit,
    output logic              in_ack,
    output logic              out_valid,
    output logic              io_wait,
    output logic              halted
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        WAIT_IN  = 2'd1,
        WAIT_OUT = 2'd2,
        HALTED   = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic                armed_q, armed_d;
    logic [ADDR_W-1:0]   seq_pc;
    logic [ADDR_W-1:0]   next_pc;
    logic                take_branch;

    assign seq_pc      = pc_q + ADDR_W'(1);
    assign take_branch = branch && (alu_zero == branchtype);
    assign pc          = pc_q;
    assign pc_plus1    = seq_pc;

    // Target selection for an ordinary completing instruction
    always_comb begin
        next_pc = seq_pc;
        case (jump)
            2'b00:   next_pc = jtarget;
            2'b10:   next_pc = jreg;
            default: next_pc = take_branch ? (seq_pc + boffset) : seq_pc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            armed_q <= 1'b1;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            armed_q <= armed_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        armed_d   = armed_q;
        commit    = 1'b0;
        in_ack    = 1'b0;
        out_valid = 1'b0;
        io_wait   = 1'b0;
        halted    = 1'b0;

        case (state_q)
            RUN: begin
                if (pcctrl) begin
                    commit = 1'b1;
                    pc_d   = next_pc;
                end else if (inctrl) begin
                    if (in_valid && armed_q) begin
                        commit = 1'b1;
                        in_ack = 1'b1;
                        pc_d   = seq_pc;
                    end else begin
                        state_d = WAIT_IN;
                    end
                end else if (outctrl) begin
                    out_valid = 1'b1;
                    if (out_ready) begin
                        commit = 1'b1;
                        pc_d   = seq_pc;
                    end else begin
                        state_d = WAIT_OUT;
                    end
                end else begin
                    state_d = HALTED;
                end
            end
            WAIT_IN: begin
                io_wait = 1'b1;
                if (in_valid && armed_q) begin
                    commit  = 1'b1;
                    in_ack  = 1'b1;
                    pc_d    = seq_pc;
                    state_d = RUN;
                end
            end
            WAIT_OUT: begin
                io_wait   = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    commit  = 1'b1;
                    pc_d    = seq_pc;
                    state_d = RUN;
                end
            end
            HALTED: begin
                halted = 1'b1;
`ifdef HALT_RESUME_EN
                if (resume) begin
                    pc_d    = seq_pc;
                    state_d = RUN;
                end
`endif
            end
            default: state_d = RUN;
        endcase

        // A held input level feeds exactly one in instruction
        if (!in_valid) begin
            armed_d = 1'b1;
        end else if (in_ack) begin
            armed_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (ADDR_W=10, RESET_PC=0).
module tb_pc_sequencer;

    localparam int unsigned ADDR_W = 10;

    logic              clk;
    logic              rst_n;
    logic              pcctrl;
    logic [1:0]        jump;
    logic              branch;
    logic              branchtype;
    logic              alu_zero;
    logic              inctrl;
    logic              outctrl;
    logic [ADDR_W-1:0] jtarget;
    logic [ADDR_W-1:0] boffset;
    logic [ADDR_W-1:0] jreg;
    logic              in_valid;
    logic              out_ready;
`ifdef HALT_RESUME_EN
    logic              resume;
`endif
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus1;
    logic              commit;
    logic              in_ack;
    logic              out_valid;
    logic              io_wait;
    logic              halted;

    int n_tests;
    int n_fail;

    pc_sequencer #(.ADDR_W(ADDR_W), .RESET_PC('0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pcctrl     (pcctrl),
        .jump       (jump),
        .branch     (branch),
        .branchtype (branchtype),
        .alu_zero   (alu_zero),
        .inctrl     (inctrl),
        .outctrl    (outctrl),
        .jtarget    (jtarget),
        .boffset    (boffset),
        .jreg       (jreg),
        .in_valid   (in_valid),
        .out_ready  (out_ready),
`ifdef HALT_RESUME_EN
        .resume     (resume),
`endif
        .pc         (pc),
        .pc_plus1   (pc_plus1),
        .commit     (commit),
        .in_ack     (in_ack),
        .out_valid  (out_valid),
        .io_wait    (io_wait),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and registered values are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic seq_inputs();
        pcctrl = 1'b1; jump = 2'b01; branch = 1'b0; branchtype = 1'b0;
        alu_zero = 1'b0; inctrl = 1'b0; outctrl = 1'b0;
        jtarget = '0; boffset = '0; jreg = '0;
    endtask

    task automatic set_pc(input logic [ADDR_W-1:0] target);
        seq_inputs();
        jump = 2'b00; jtarget = target;
        step();
        seq_inputs();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        seq_inputs();
        in_valid = 1'b0; out_ready = 1'b0;
`ifdef HALT_RESUME_EN
        resume = 1'b0;
`endif
        step(); step();
        n_tests++;
        if (pc !== 10'd0 || halted !== 1'b0 || io_wait !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: pc=%0h halted=%b io_wait=%b, want pc=0 halted=0 io_wait=0", pc, halted, io_wait);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++;
            if (pc !== 10'(i) || commit !== 1'b1) begin
                n_fail++;
                $display("FAIL seq[%0d]: pc=%0h commit=%b, want pc=%0h commit=1", i, pc, commit, i);
            end
            step();
        end
        n_tests++;
        if (pc !== 10'd5) begin
            n_fail++;
            $display("FAIL seq_end: pc=%0h, want 5", pc);
        end
    endtask

    task automatic test_branch();
        // beq taken: 8 + 1 - 3 = 6
        set_pc(10'd8);
        branch = 1'b1; branchtype = 1'b1; alu_zero = 1'b1; boffset = 10'h3FD;
        step();
        n_tests++;
        if (pc !== 10'd6) begin
            n_fail++;
            $display("FAIL beq_taken: pc=%0h, want 6", pc);
        end
        set_pc(10'd8);
        branch = 1'b1; branchtype = 1'b1; alu_zero = 1'b0; boffset = 10'h3FD;
        step();
        n_tests++;
        if (pc !== 10'd9) begin
            n_fail++;
            $display("FAIL beq_not_taken: pc=%0h, want 9", pc);
        end
        set_pc(10'd8);
        branch = 1'b1; branchtype = 1'b0; alu_zero = 1'b0; boffset = 10'h3FD;
        step();
        n_tests++;
        if (pc !== 10'd6) begin
            n_fail++;
            $display("FAIL bne_taken: pc=%0h, want 6", pc);
        end
        seq_inputs();
    endtask

    task automatic test_jump();
        set_pc(10'h120);
        n_tests++;
        if (pc !== 10'h120) begin
            n_fail++;
            $display("FAIL jump_imm: pc=%0h, want 120", pc);
        end
        jump = 2'b10; jreg = 10'h3FF;
        step();
        n_tests++;
        if (pc !== 10'h3FF) begin
            n_fail++;
            $display("FAIL jump_reg: pc=%0h, want 3ff", pc);
        end
        seq_inputs();
        jump = 2'b11;
        step();
        n_tests++;
        if (pc !== 10'd0) begin
            n_fail++;
            $display("FAIL pc_wrap: pc=%0h, want 0", pc);
        end
        set_pc(10'd4);
        jump = 2'b00; jtarget = 10'h050;
        @(negedge clk);
        n_tests++;
        if (pc_plus1 !== 10'd5 || commit !== 1'b1) begin
            n_fail++;
            $display("FAIL jal_link: pc_plus1=%0h commit=%b, want 5 and 1", pc_plus1, commit);
        end
        step();
        n_tests++;
        if (pc !== 10'h050) begin
            n_fail++;
            $display("FAIL jal_target: pc=%0h, want 50", pc);
        end
        seq_inputs();
    endtask

    task automatic test_input();
        int waits;
        set_pc(10'd3);
        pcctrl = 1'b0; inctrl = 1'b1; in_valid = 1'b0;
        waits = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (io_wait === 1'b1) waits++;
            n_tests++;
            if (commit !== 1'b0 || in_ack !== 1'b0 || pc !== 10'd3) begin
                n_fail++;
                $display("FAIL in_stall[%0d]: commit=%b in_ack=%b pc=%0h, want 0 0 3", i, commit, in_ack, pc);
            end
            step();
        end
        in_valid = 1'b1;
        @(negedge clk);
        if (io_wait === 1'b1) waits++;
        n_tests++;
        if (in_ack !== 1'b1 || commit !== 1'b1) begin
            n_fail++;
            $display("FAIL in_accept: in_ack=%b commit=%b, want 1 1", in_ack, commit);
        end
        step();
        n_tests++;
        if (pc !== 10'd4 || waits != 4 || io_wait !== 1'b0) begin
            n_fail++;
            $display("FAIL in_done: pc=%0h io_wait_cycles=%0d io_wait=%b, want 4 4 0", pc, waits, io_wait);
        end
        // Same input level must not be consumed twice
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_tests++;
            if (in_ack !== 1'b0 || commit !== 1'b0) begin
                n_fail++;
                $display("FAIL in_rearm_hold[%0d]: in_ack=%b commit=%b, want 0 0", i, in_ack, commit);
            end
            step();
        end
        in_valid = 1'b0;
        step();
        in_valid = 1'b1;
        @(negedge clk);
        n_tests++;
        if (in_ack !== 1'b1 || commit !== 1'b1) begin
            n_fail++;
            $display("FAIL in_rearm_accept: in_ack=%b commit=%b, want 1 1", in_ack, commit);
        end
        step();
        n_tests++;
        if (pc !== 10'd5) begin
            n_fail++;
            $display("FAIL in_rearm_pc: pc=%0h, want 5", pc);
        end
        in_valid = 1'b0;
        seq_inputs();
    endtask

    task automatic test_output();
        int ov;
        int cm;
        set_pc(10'd5);
        pcctrl = 1'b0; outctrl = 1'b1; out_ready = 1'b0;
        ov = 0; cm = 0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) out_ready = 1'b1;
            @(negedge clk);
            if (out_valid === 1'b1) ov++;
            if (commit === 1'b1) cm++;
            step();
        end
        n_tests++;
        if (ov != 3 || cm != 1 || pc !== 10'd6) begin
            n_fail++;
            $display("FAIL out_handshake: out_valid_cycles=%0d commits=%0d pc=%0h, want 3 1 6", ov, cm, pc);
        end
        out_ready = 1'b0;
        step();
        n_tests++;
        if (io_wait !== 1'b1 || out_valid !== 1'b1 || pc !== 10'd6) begin
            n_fail++;
            $display("FAIL out_wait: io_wait=%b out_valid=%b pc=%0h, want 1 1 6", io_wait, out_valid, pc);
        end
        // Reset mid-wait; decoder now sees the instruction at pc 0 as a bubble
        rst_n = 1'b0;
        pcctrl = 1'b0; outctrl = 1'b0; inctrl = 1'b0;
        #1;
        n_tests++;
        if (pc !== 10'd0 || out_valid !== 1'b0 || commit !== 1'b0 || io_wait !== 1'b0 || in_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL out_reset: pc=%0h out_valid=%b commit=%b io_wait=%b in_ack=%b, want 0 0 0 0 0",
                     pc, out_valid, commit, io_wait, in_ack);
        end
        step();
        seq_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_halt();
        int bad;
        set_pc(10'd7);
        pcctrl = 1'b0;
        @(negedge clk);
        n_tests++;
        if (commit !== 1'b0 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_entry: commit=%b halted=%b, want 0 0", commit, halted);
        end
        step();
        // Decoder inputs are don't-care while halted; drive a completing instruction
        seq_inputs();
        in_valid = 1'b1; out_ready = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (halted !== 1'b1 || pc !== 10'd7 || commit !== 1'b0 || in_ack !== 1'b0 || out_valid !== 1'b0) bad++;
            step();
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL halt_hold: bad_cycles=%0d pc=%0h halted=%b, want 0 7 1", bad, pc, halted);
        end
        in_valid = 1'b0; out_ready = 1'b0;
`ifdef HALT_RESUME_EN
        resume = 1'b1;
        @(negedge clk);
        n_tests++;
        if (commit !== 1'b0) begin
            n_fail++;
            $display("FAIL resume_commit: commit=%b, want 0", commit);
        end
        step();
        resume = 1'b0;
        n_tests++;
        if (pc !== 10'd8 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL resume: pc=%0h halted=%b, want 8 0", pc, halted);
        end
`else
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (pc !== 10'd0 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_reset: pc=%0h halted=%b, want 0 0", pc, halted);
        end
        step();
        rst_n = 1'b1;
`endif
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_input();
        test_output();
        test_halt();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
